test_sequencer: RTL

- Synthesizable sequencer that runs N self-test channels (SPI, BRAM, arbiter, ...) one at a time.
- Issues a start pulse to each channel and waits for its done/pass handshake, with a per-channel cycle timeout.
- Aggregates pass, fail and timeout masks into a final verdict.
- Parametrised, on-chip successor to the simulation-only test harness; sits beside the system bus logic and is driven by the MCU or a power-on trigger.

---
 rtl/test_seq_pkg.sv | 26 ++
 rtl/test_seq_timer.sv | 32 +++
 rtl/test_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/test_seq_pkg.sv
// Shared types and helpers for the test sequencer: FSM state encoding,
// channel-index width helper and the default per-channel timeout.
package test_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_NEXT  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   localparam int DEFAULT_CLK_MHZ        = 64;
   localparam int DEFAULT_TIMEOUT_CYCLES = DEFAULT_CLK_MHZ * 1000;

   // Width of the channel index; never narrower than one bit.
   function automatic int ch_width(input int num_ch);
      return (num_ch <= 2) ? 1 : $clog2(num_ch);
   endfunction

   // Default timeout: one millisecond worth of clock cycles.
   function automatic int timeout_from_mhz(input int clk_mhz);
      return clk_mhz * 1000;
   endfunction

endpackage

// File: rtl/test_seq_timer.sv
// Loadable down-counter with synchronous clear. expired is high whenever
// the count sits at zero; the count never wraps below zero. Generic enough
// to serve as a watchdog elsewhere.
module test_seq_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         expired
);

   // Counter register: clear beats load, load beats decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/test_sequencer.sv
// Runs NUM_CH self-test channels one after another, giving each a start
// pulse and a bounded wait for its done/pass strobe, and collects the
// results into pass, fail and timeout masks.
//
// Optional build macro: TEST_SEQ_STOP_ON_FAIL_EN -- when defined, the first
// fail or timeout ends the sequence (complete_o still pulses) and later
// channels stay unmarked.
//
// Channel handshake: start_o[i] is a single-cycle pulse; the channel answers
// later with a single-cycle done_i[i], and pass_i[i] is only meaningful in
// that same cycle. done_i/pass_i of channels other than the active one are
// ignored.
module test_sequencer
   import test_seq_pkg::*;
#(
   parameter int CLK_MHZ        = DEFAULT_CLK_MHZ,
   parameter int NUM_CH         = 5,
   parameter int TIMEOUT_CYCLES = timeout_from_mhz(CLK_MHZ),
   parameter int CH_W           = ch_width(NUM_CH)
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              run_i,
   input  logic              abort_i,
   output logic [NUM_CH-1:0] start_o,
   input  logic [NUM_CH-1:0] done_i,
   input  logic [NUM_CH-1:0] pass_i,
   output logic              busy_o,
   output logic [CH_W-1:0]   ch_idx_o,
   output logic [NUM_CH-1:0] pass_mask_o,
   output logic [NUM_CH-1:0] fail_mask_o,
   output logic [NUM_CH-1:0] timeout_mask_o,
   output logic              complete_o,
   output logic              all_pass_o,
   output seq_state_t        state_o
);

`ifdef TEST_SEQ_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES);
   // Loaded in START so the counter reaches zero on the TIMEOUT_CYCLES-th WAIT cycle.
   localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CH_W-1:0]   LAST_IDX = CH_W'(NUM_CH - 1);
   localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

   seq_state_t        state;
   logic [NUM_CH-1:0] start_r;
   logic [CH_W-1:0]   nxt_idx;
   logic              done_sel;
   logic              pass_sel;
   logic              tmr_clear;
   logic              tmr_load;
   logic              tmr_en;
   logic              tmr_expired;
   logic [TMR_W-1:0]  tmr_count;

   assign nxt_idx   = ch_idx_o + CH_W'(1);
   assign done_sel  = done_i[ch_idx_o];
   assign pass_sel  = pass_i[ch_idx_o];

   assign tmr_clear = (state == ST_IDLE);
   assign tmr_load  = (state == ST_START);
   assign tmr_en    = (state == ST_WAIT) && !done_sel && !abort_i;

   test_seq_timer #(.W(TMR_W)) u_timer (
      .clk      (clk_i),
      .rst_n    (reset_n_i),
      .clear    (tmr_clear),
      .load     (tmr_load),
      .load_val (TMR_LOAD),
      .en       (tmr_en),
      .count    (tmr_count),
      .expired  (tmr_expired)
   );

   // An abort in the cycle of a start pulse suppresses that pulse.
   assign start_o = start_r & ~{NUM_CH{abort_i}};
   assign state_o = state;

   // Sequencer FSM with registered start, mask, busy and verdict outputs.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state          <= ST_IDLE;
         ch_idx_o       <= '0;
         start_r        <= '0;
         busy_o         <= 1'b0;
         pass_mask_o    <= '0;
         fail_mask_o    <= '0;
         timeout_mask_o <= '0;
         complete_o     <= 1'b0;
         all_pass_o     <= 1'b0;
      end else begin
         start_r    <= '0;
         complete_o <= 1'b0;
         if (abort_i && (state != ST_IDLE)) begin
            state      <= ST_IDLE;
            busy_o     <= 1'b0;
            all_pass_o <= &pass_mask_o;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (run_i) begin
                     pass_mask_o    <= '0;
                     fail_mask_o    <= '0;
                     timeout_mask_o <= '0;
                     ch_idx_o       <= '0;
                     start_r        <= ONE_HOT0;
                     busy_o         <= 1'b1;
                     state          <= ST_START;
                  end
               end
               ST_START: begin
                  state <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (done_sel) begin
                     pass_mask_o[ch_idx_o] <= pass_sel;
                     fail_mask_o[ch_idx_o] <= ~pass_sel;
                     if (STOP_ON_FAIL && !pass_sel) begin
                        state      <= ST_DONE;
                        complete_o <= 1'b1;
                        all_pass_o <= 1'b0;
                     end else begin
                        state <= ST_NEXT;
                     end
                  end else if (tmr_expired) begin
                     timeout_mask_o[ch_idx_o] <= 1'b1;
                     if (STOP_ON_FAIL) begin
                        state      <= ST_DONE;
                        complete_o <= 1'b1;
                        all_pass_o <= 1'b0;
                     end else begin
                        state <= ST_NEXT;
                     end
                  end
               end
               ST_NEXT: begin
                  if (ch_idx_o == LAST_IDX) begin
                     state      <= ST_DONE;
                     complete_o <= 1'b1;
                     all_pass_o <= &pass_mask_o;
                  end else begin
                     ch_idx_o <= nxt_idx;
                     start_r  <= ONE_HOT0 << nxt_idx;
                     state    <= ST_START;
                  end
               end
               ST_DONE: begin
                  state      <= ST_IDLE;
                  busy_o     <= 1'b0;
                  all_pass_o <= &pass_mask_o;
               end
               default: begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
